// File: rtl/mem_req_ctrl_if.sv
// Request, data-bus and response signals of the memory request controller.
// master: the controller itself; slave: the pipeline/memory side around it.
interface mem_req_ctrl_if;
  // MEM-stage request
  logic        req_valid;
  logic        req_wr;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  // pipeline control
  logic        flush;
  logic        wb_ready;
  logic        stall;
  // sram-like data bus
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  // writeback response
  logic        rsp_valid;
  logic        rsp_wr;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_addr_lo;

  modport master (
    input  req_valid, req_wr, req_size, req_addr, req_wdata, req_wstrb,
    input  flush, wb_ready,
    output stall,
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok, data_rdata,
    output rsp_valid, rsp_wr, rsp_rdata, rsp_addr_lo
  );

  modport slave (
    output req_valid, req_wr, req_size, req_addr, req_wdata, req_wstrb,
    output flush, wb_ready,
    input  stall,
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok, data_rdata,
    input  rsp_valid, rsp_wr, rsp_rdata, rsp_addr_lo
  );
endinterface

// File: rtl/mem_req_ctrl.sv
// Memory request controller: turns one MEM-stage load/store at a time into an
// sram-like bus transaction, holds the response until writeback takes it,
// and cancels or drains cleanly on flush.
module mem_req_ctrl (
  input  logic           clk,
  input  logic           rst,
  mem_req_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_rdata;

  logic        w_accept;
  logic        w_capture;
  logic        w_stall;

  // A request is taken only from IDLE and only when not being cancelled.
  assign w_accept  = (r_state == IDLE) && bus.req_valid && !bus.flush;
  // Response is kept only when the data beat arrives without a flush.
  assign w_capture = (r_state == DATA) && bus.data_data_ok && !bus.flush;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Latch the request so the bus sees stable fields independent of the core.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_wstrb <= 4'h0;
    end else if (w_accept) begin
      r_wr    <= bus.req_wr;
      r_size  <= bus.req_size;
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
      // Loads never carry byte enables onto the bus.
      r_wstrb <= bus.req_wr ? bus.req_wstrb : 4'h0;
    end
  end

  // Capture the raw bus word; stores report zero so writeback sees a clean value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= 32'h0;
    end else if (w_capture) begin
      r_rdata <= r_wr ? 32'h0 : bus.data_rdata;
    end
  end

  // Next-state logic; handshakes arriving in states that don't expect them fall through.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_next = ADDR;
      end
      ADDR: begin
        if (bus.data_addr_ok) begin
          // Address already accepted: a flush must still wait out the data beat.
          w_state_next = bus.flush ? DRAIN : DATA;
        end else if (bus.flush) begin
          w_state_next = IDLE;
        end
      end
      DATA: begin
        if (bus.data_data_ok) begin
          w_state_next = bus.flush ? IDLE : HOLD;
        end else if (bus.flush) begin
          w_state_next = DRAIN;
        end
      end
      HOLD: begin
        // Flush and wb_ready both retire; with flush the response is simply dropped.
        if (bus.flush || bus.wb_ready) w_state_next = IDLE;
      end
      DRAIN: begin
        if (bus.data_data_ok) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Stall back to the requester while a transaction is in flight or starting.
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      IDLE:    w_stall = bus.req_valid && !bus.flush;
      ADDR:    w_stall = 1'b1;
      DATA:    w_stall = 1'b1;
      DRAIN:   w_stall = 1'b1;
      HOLD:    w_stall = !bus.wb_ready;
      default: w_stall = 1'b0;
    endcase
    if (rst) w_stall = 1'b0;
  end

  assign bus.stall       = w_stall;

  assign bus.data_req    = (r_state == ADDR);
  assign bus.data_wr     = r_wr;
  assign bus.data_size   = r_size;
  assign bus.data_addr   = r_addr;
  assign bus.data_wdata  = r_wdata;
  assign bus.data_wstrb  = r_wstrb;

  assign bus.rsp_valid   = (r_state == HOLD);
  assign bus.rsp_wr      = r_wr;
  assign bus.rsp_rdata   = r_rdata;
  assign bus.rsp_addr_lo = r_addr[1:0];

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: load, delayed store, flush cases,
// writeback back-pressure, back-to-back request and reset mid-transaction.
module tb_mem_req_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_req_ctrl_if bus ();

  mem_req_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_size  = size;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wstrb = wstrb;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_size = 2'd0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.req_wstrb = 4'h0;
    bus.flush = 1'b0; bus.wb_ready = 1'b0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;

    // ---- reset state ----
    #1;
    chk1("rst_stall", bus.stall, 1'b0);
    tick();
    chk1("rst_data_req", bus.data_req, 1'b0);
    chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_data_addr", bus.data_addr, 32'h0);
    rst = 1'b0;
    bus.req_valid = 1'b0;
    tick();

    // ---- load word, minimum latency ----
    set_req(1'b0, 2'd2, 32'h1000_0004, 32'h1234_5678, 4'hF);
    #1;
    chk1("ld_idle_stall", bus.stall, 1'b1);
    chk1("ld_idle_no_req", bus.data_req, 1'b0);
    tick();
    bus.data_addr_ok = 1'b1;
    #1;
    chk1("ld_data_req", bus.data_req, 1'b1);
    chk("ld_data_addr", bus.data_addr, 32'h1000_0004);
    chk("ld_data_wstrb", 32'(bus.data_wstrb), 32'h0);
    chk1("ld_data_wr", bus.data_wr, 1'b0);
    chk("ld_data_size", 32'(bus.data_size), 32'h2);
    tick();
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'hDEAD_BEEF;
    #1;
    chk1("ld_data_no_req", bus.data_req, 1'b0);
    chk1("ld_data_no_rsp", bus.rsp_valid, 1'b0);
    chk1("ld_data_stall", bus.stall, 1'b1);
    tick();
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = 32'h0;
    bus.wb_ready     = 1'b1;
    #1;
    chk1("ld_rsp_valid", bus.rsp_valid, 1'b1);
    chk("ld_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    chk("ld_rsp_addr_lo", 32'(bus.rsp_addr_lo), 32'h0);
    chk1("ld_rsp_wr", bus.rsp_wr, 1'b0);
    chk1("ld_hold_stall", bus.stall, 1'b0);
    tick();
    bus.req_valid = 1'b0;
    bus.wb_ready  = 1'b0;
    #1;
    chk1("ld_done_rsp", bus.rsp_valid, 1'b0);
    chk1("ld_done_req", bus.data_req, 1'b0);

    // ---- store byte, addr_ok delayed 4 cycles ----
    set_req(1'b1, 2'd0, 32'h2000_0003, 32'hAB00_0000, 4'b1000);
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.data_addr_ok = (i == 4);
      #1;
      chk1($sformatf("st_req_%0d", i), bus.data_req, 1'b1);
      chk($sformatf("st_addr_%0d", i), bus.data_addr, 32'h2000_0003);
      chk($sformatf("st_wstrb_%0d", i), 32'(bus.data_wstrb), 32'h8);
      chk($sformatf("st_wdata_%0d", i), bus.data_wdata, 32'hAB00_0000);
      chk1($sformatf("st_wr_%0d", i), bus.data_wr, 1'b1);
      chk1($sformatf("st_stall_%0d", i), bus.stall, 1'b1);
      tick();
    end
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'h5555_5555;
    #1;
    chk1("st_data_no_req", bus.data_req, 1'b0);
    tick();
    bus.data_data_ok = 1'b0;
    bus.wb_ready     = 1'b1;
    #1;
    chk1("st_rsp_valid", bus.rsp_valid, 1'b1);
    chk1("st_rsp_wr", bus.rsp_wr, 1'b1);
    chk("st_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("st_rsp_addr_lo", 32'(bus.rsp_addr_lo), 32'h3);
    tick();
    bus.req_valid = 1'b0;
    bus.wb_ready  = 1'b0;

    // ---- flush in ADDR without addr_ok ----
    set_req(1'b0, 2'd2, 32'h3000_0008, 32'h0, 4'h0);
    tick();
    bus.flush = 1'b1;
    #1;
    chk1("fa_req_before", bus.data_req, 1'b1);
    tick();
    bus.flush = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    chk1("fa_req_after", bus.data_req, 1'b0);
    chk1("fa_stall", bus.stall, 1'b0);
    chk1("fa_rsp", bus.rsp_valid, 1'b0);
    tick();
    chk1("fa_rsp2", bus.rsp_valid, 1'b0);

    // ---- flush together with addr_ok -> drain ----
    set_req(1'b0, 2'd2, 32'h3000_0010, 32'h0, 4'h0);
    tick();
    bus.data_addr_ok = 1'b1;
    bus.flush        = 1'b1;
    tick();
    bus.data_addr_ok = 1'b0;
    bus.flush        = 1'b0;
    bus.req_valid    = 1'b0;
    #1;
    chk1("dr_req", bus.data_req, 1'b0);
    chk1("dr_stall0", bus.stall, 1'b1);
    chk1("dr_rsp0", bus.rsp_valid, 1'b0);
    tick();
    bus.flush = 1'b1;
    #1;
    chk1("dr_stall1", bus.stall, 1'b1);
    tick();
    bus.flush        = 1'b0;
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'h1111_1111;
    #1;
    chk1("dr_stall2", bus.stall, 1'b1);
    chk1("dr_req2", bus.data_req, 1'b0);
    tick();
    bus.data_data_ok = 1'b0;
    #1;
    chk1("dr_idle_stall", bus.stall, 1'b0);
    chk1("dr_idle_rsp", bus.rsp_valid, 1'b0);
    chk("dr_rdata_kept", bus.rsp_rdata, 32'h0);

    // ---- stray handshakes in IDLE are ignored ----
    bus.data_addr_ok = 1'b1;
    bus.data_data_ok = 1'b1;
    tick();
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    #1;
    chk1("stray_req", bus.data_req, 1'b0);
    chk1("stray_rsp", bus.rsp_valid, 1'b0);
    chk1("stray_stall", bus.stall, 1'b0);

    // ---- writeback back-pressure then back-to-back request ----
    set_req(1'b0, 2'd1, 32'h4000_0002, 32'h0, 4'h3);
    tick();
    bus.data_addr_ok = 1'b1;
    tick();
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'hCAFE_F00D;
    tick();
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = 32'h0;
    for (int i = 0; i < 4; i++) begin
      bus.wb_ready = (i == 3);
      #1;
      chk1($sformatf("bp_valid_%0d", i), bus.rsp_valid, 1'b1);
      chk($sformatf("bp_rdata_%0d", i), bus.rsp_rdata, 32'hCAFE_F00D);
      chk($sformatf("bp_lo_%0d", i), 32'(bus.rsp_addr_lo), 32'h2);
      chk1($sformatf("bp_stall_%0d", i), bus.stall, (i != 3));
      tick();
    end
    bus.wb_ready = 1'b0;
    set_req(1'b0, 2'd2, 32'h5000_0000, 32'h0102_0304, 4'hF);
    #1;
    chk1("b2b_idle_rsp", bus.rsp_valid, 1'b0);
    chk1("b2b_idle_req", bus.data_req, 1'b0);
    chk1("b2b_idle_stall", bus.stall, 1'b1);
    tick();
    bus.data_addr_ok = 1'b1;
    #1;
    chk1("b2b_req", bus.data_req, 1'b1);
    chk("b2b_addr", bus.data_addr, 32'h5000_0000);
    tick();
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'h0BAD_F00D;
    #1;
    chk1("b2b_one_txn", bus.data_req, 1'b0);
    tick();
    bus.data_data_ok = 1'b0;
    bus.flush        = 1'b1;
    bus.wb_ready     = 1'b1;
    #1;
    chk1("b2b_rsp", bus.rsp_valid, 1'b1);
    chk("b2b_rdata", bus.rsp_rdata, 32'h0BAD_F00D);
    tick();
    bus.flush     = 1'b0;
    bus.wb_ready  = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    chk1("hf_rsp", bus.rsp_valid, 1'b0);
    chk1("hf_req", bus.data_req, 1'b0);

    // ---- reset during DATA, then a late data_ok ----
    set_req(1'b1, 2'd1, 32'h6000_0007, 32'hFEED_0001, 4'hC);
    tick();
    bus.data_addr_ok = 1'b1;
    tick();
    bus.data_addr_ok = 1'b0;
    rst = 1'b1;
    #1;
    chk1("rd_stall_rst", bus.stall, 1'b0);
    tick();
    #1;
    chk1("rd_req", bus.data_req, 1'b0);
    chk1("rd_rsp", bus.rsp_valid, 1'b0);
    chk("rd_rdata", bus.rsp_rdata, 32'h0);
    chk1("rd_rsp_wr", bus.rsp_wr, 1'b0);
    chk("rd_lo", 32'(bus.rsp_addr_lo), 32'h0);
    chk("rd_addr", bus.data_addr, 32'h0);
    chk("rd_wdata", bus.data_wdata, 32'h0);
    chk("rd_wstrb", 32'(bus.data_wstrb), 32'h0);
    chk1("rd_stall", bus.stall, 1'b0);
    rst = 1'b0;
    bus.req_valid    = 1'b0;
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'h7777_7777;
    tick();
    bus.data_data_ok = 1'b0;
    #1;
    chk1("late_rsp", bus.rsp_valid, 1'b0);
    chk1("late_stall", bus.stall, 1'b0);
    tick();
    chk1("late_rsp2", bus.rsp_valid, 1'b0);
    chk("late_rdata", bus.rsp_rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_req_ctrl.md
MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, the single clock; rst in 1, synchronous, active-high reset.
REQ-002 SHALL have ports: req_valid in 1 (MEM-stage load/store request), req_wr in 1 (1=store), req_size in 2 (0=byte, 1=half, 2=word), req_addr in 32, req_wdata in 32, req_wstrb in 4.
REQ-003 SHALL have ports: flush in 1 (exception/eret cancel); wb_ready in 1 (writeback accepts response); stall out 1 (requester holds all req_* stable while high).
REQ-004 SHALL have ports: data_req out 1, data_wr out 1, data_size out 2, data_addr out 32, data_wdata out 32, data_wstrb out 4, data_addr_ok in 1, data_data_ok in 1, data_rdata in 32 (sram-like data bus).
REQ-005 SHALL have ports: rsp_valid out 1, rsp_wr out 1, rsp_rdata out 32 (raw bus word, unshifted), rsp_addr_lo out 2 (req_addr[1:0] for writeback byte select).

Function
REQ-006 SHALL implement states IDLE, ADDR, DATA, HOLD, DRAIN in a registered state machine.
REQ-007 IDLE: req_valid=1 and flush=0 SHALL latch req_* into internal registers and go to ADDR next cycle; otherwise stay in IDLE.
REQ-008 data_req SHALL be 1 only in ADDR; data_wr/size/addr/wdata/wstrb SHALL drive the latched values and stay stable until data_addr_ok.
REQ-009 For loads, data_wstrb SHALL be 4'b0000 regardless of req_wstrb.
REQ-010 ADDR: data_addr_ok=1 -> DATA; flush=1 with data_addr_ok=0 -> IDLE (request withdrawn, nothing outstanding); flush=1 with data_addr_ok=1 -> DRAIN.
REQ-011 DATA: data_data_ok=1 and flush=0 -> HOLD, capturing data_rdata into rsp_rdata (loads) or 32'h0 (stores); flush=1 with data_data_ok=1 -> IDLE, response discarded; flush=1 with data_data_ok=0 -> DRAIN.
REQ-012 DRAIN: data_req=0; data_data_ok=1 -> IDLE, response discarded; flush ignored.
REQ-013 HOLD: rsp_valid=1, rsp_wr and rsp_addr_lo from latched request; wb_ready=1 -> IDLE; flush=1 -> IDLE with no response delivered (flush wins over wb_ready).
REQ-014 rsp_valid SHALL be 1 only in HOLD; rsp_rdata SHALL hold its captured value until the next capture.
REQ-015 stall SHALL be combinational: 1 in ADDR, DATA, DRAIN; 1 in HOLD when wb_ready=0; 1 in IDLE when req_valid=1 and flush=0; else 0.
REQ-016 At most one bus transaction SHALL be outstanding; data_req SHALL never be asserted in DATA or DRAIN.
REQ-017 data_addr_ok or data_data_ok arriving in a state that does not expect it SHALL be ignored with no state change.
REQ-018 Minimum load latency: req_valid cycle N -> data_req N+1 -> (addr_ok N+1, data_ok N+2) -> rsp_valid N+3.
REQ-019 Back-to-back: request accepted in IDLE the cycle after HOLD retires; no request dropped or duplicated.

Reset
REQ-020 rst=1 SHALL force state IDLE and, next cycle, data_req=0, rsp_valid=0, rsp_rdata=0, rsp_wr=0, rsp_addr_lo=0, all latched request fields=0, regardless of state.
REQ-021 Reset mid-transaction SHALL abandon any outstanding bus response (the bus is reset together with the core); stall=0 while rst=1.

Verification
REQ-022 Load word addr 0x1000_0004, addr_ok same cycle as data_req, data_ok next cycle with 0xDEAD_BEEF -> rsp_valid 3 cycles after req_valid, rsp_rdata=0xDEAD_BEEF, rsp_addr_lo=0, data_wstrb=0.
REQ-023 Store byte addr 0x...03, wstrb 4'b1000, addr_ok delayed 4 cycles -> data_req held 5 cycles with constant fields, stall=1 throughout, rsp_valid with rsp_wr=1, rsp_rdata=0.
REQ-024 flush in ADDR without addr_ok -> IDLE next cycle, data_req=0, no rsp_valid; flush same cycle as addr_ok -> DRAIN, stall=1 until data_ok, then IDLE, no rsp_valid.
REQ-025 HOLD with wb_ready=0 for 3 cycles then 1 -> rsp_valid/rsp_rdata stable 4 cycles; following held request issues data_req the next cycle, exactly one transaction.
REQ-026 rst=1 during DATA -> next cycle all outputs at REQ-020 values; late data_ok after reset -> ignored, rsp_valid stays 0.
